// File: rtl/envelope_follower.sv
// envelope_follower
//   Amplitude-envelope detector for the audio sample path. Tracks a smoothed
//   envelope (fast attack, slow release). It also reports the peak magnitude
//   of each fixed-length window of strobes and classifies the envelope phase
//   by comparing successive window peaks.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset, clears all state
//   sample_in   signed 16-bit sample, qualified by in_ready
//   in_ready    sample strobe, one cycle per sample, may be continuous
//   env_out     smoothed envelope magnitude, 0..32767
//   env_valid   one-cycle pulse when env_out updates (2 cycles after in_ready)
//   peak_out    max |sample| of the last completed window
//   peak_valid  one-cycle pulse when peak_out and phase update
//   phase       0=SILENT 1=RISING 2=STEADY 3=FALLING
//
// Phase states
//   state      | meaning
//   PH_SILENT  | last window peak below SILENCE
//   PH_RISING  | last peak exceeds previous peak by more than HYST
//   PH_STEADY  | last peak within HYST of previous peak
//   PH_FALLING | last peak below previous peak by more than HYST

module envelope_follower #(
   parameter int ATTACK_SHIFT  = 2,
   parameter int RELEASE_SHIFT = 6,
   parameter int WINDOW        = 480,
   parameter int HYST          = 64,
   parameter int SILENCE       = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] sample_in,
   input  logic        in_ready,
   output logic [15:0] env_out,
   output logic        env_valid,
   output logic [15:0] peak_out,
   output logic        peak_valid,
   output logic [1:0]  phase
);

   localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   typedef enum logic [1:0] {
      PH_SILENT  = 2'd0,
      PH_RISING  = 2'd1,
      PH_STEADY  = 2'd2,
      PH_FALLING = 2'd3
   } phase_t;

   phase_t      phase_q, phase_nxt;

   logic [CW-1:0] count;
   logic [15:0]   mag_in;
   logic          last_hit;

   logic          s1_valid;
   logic [15:0]   s1_mag;
   logic          s1_last;

   logic [15:0]   env_q;
   logic [15:0]   env_nxt;
   logic [15:0]   diff_up, diff_dn, step_up, step_dn;
   logic [15:0]   run_max;
   logic [15:0]   prev_peak;
   logic [15:0]   peak_q;
   logic [15:0]   win_peak;
   logic [16:0]   p17, q17;

   // ---------------- stage 1: magnitude and window position ----------------
   // -32768 has no positive 16-bit counterpart, so it saturates to 32767.
   always_comb begin
      if (!sample_in[15])
         mag_in = sample_in;
      else if (sample_in == 16'h8000)
         mag_in = 16'h7fff;
      else
         mag_in = 16'd0 - sample_in;
   end

   assign last_hit = (count == CW'(WINDOW - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= '0;
         s1_valid <= 1'b0;
         s1_mag   <= '0;
         s1_last  <= 1'b0;
      end else begin
         s1_valid <= in_ready;
         if (in_ready) begin
            s1_mag  <= mag_in;
            s1_last <= last_hit;
            count   <= last_hit ? '0 : count + CW'(1);
         end
      end
   end

   // ---------------- stage 2: envelope smoothing ----------------
   // Both operands are at most 32767, so 16 unsigned bits carry the full
   // 17-bit signed range: differences taken only in the non-negative
   // direction never wrap, and the step never exceeds the difference, so
   // env cannot overshoot a or leave 0..32767.
   assign diff_up = s1_mag - env_q;
   assign diff_dn = env_q - s1_mag;

   always_comb begin
      step_up = diff_up >> ATTACK_SHIFT;
      if (step_up == 16'd0) step_up = 16'd1;
      step_dn = diff_dn >> RELEASE_SHIFT;
      if (step_dn == 16'd0) step_dn = 16'd1;

      env_nxt = env_q;
      if (s1_mag > env_q)
         env_nxt = env_q + step_up;
      else if (s1_mag < env_q)
         env_nxt = env_q - step_dn;
   end

   // The boundary sample belongs to the window it closes.
   assign win_peak = (s1_mag > run_max) ? s1_mag : run_max;
   assign p17      = {1'b0, win_peak};
   assign q17      = {1'b0, prev_peak};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         env_q      <= '0;
         env_valid  <= 1'b0;
         peak_valid <= 1'b0;
         peak_q     <= '0;
         run_max    <= '0;
         prev_peak  <= '0;
      end else begin
         env_valid  <= s1_valid;
         peak_valid <= s1_valid & s1_last;
         if (s1_valid) begin
            env_q <= env_nxt;
            if (s1_last) begin
               peak_q    <= win_peak;
               prev_peak <= win_peak;
               run_max   <= '0;
            end else begin
               run_max   <= win_peak;
            end
         end
      end
   end

   // ---------------- phase FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         phase_q <= PH_SILENT;
      else
         phase_q <= phase_nxt;
   end

   always_comb begin
      phase_nxt = phase_q;
      if (s1_valid && s1_last) begin
         if (p17 < 17'(SILENCE))
            phase_nxt = PH_SILENT;
         else if (p17 > q17 + 17'(HYST))
            phase_nxt = PH_RISING;
         else if (p17 + 17'(HYST) < q17)
            phase_nxt = PH_FALLING;
         else
            phase_nxt = PH_STEADY;
      end
   end

   assign env_out  = env_q;
   assign peak_out = peak_q;
   assign phase    = phase_q;

endmodule

// File: doc/envelope_follower.md
Name: envelope_follower

Overview:
- Amplitude-envelope detector; the analysis (decode) counterpart of the ADSR envelope shaper.
- Consumes signed 16-bit samples on the codec sample strobe (48 kHz) and produces:
  - a smoothed envelope magnitude;
  - a per-window peak;
  - a classified envelope phase (silent/rising/steady/falling).
- Sits on the sample path after the envelope shaper or effects chain. Feeds metering, auto-gain and test-bench self-checking of envelope shape.

Parameters:
- ATTACK_SHIFT, 2, right-shift applied to the upward envelope correction (fast rise).
- RELEASE_SHIFT, 6, right-shift applied to the downward envelope correction (slow decay).
- WINDOW, 480, number of sample strobes per peak window (10 ms at 48 kHz).
- HYST, 64, peak-to-peak difference needed to declare RISING or FALLING.
- SILENCE, 32, window peak strictly below this value is classified SILENT.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset; clears all state.
- sample_in  input  16  signed two's-complement sample; valid only when in_ready=1.
- in_ready  input  1  sample strobe, one cycle per sample; may be high on consecutive cycles.
- env_out  output  16  unsigned smoothed envelope, range 0..32767.
- env_valid  output  1  one-cycle pulse when env_out updates.
- peak_out  output  16  unsigned maximum |sample| of the last completed window.
- peak_valid  output  1  one-cycle pulse when peak_out and phase update.
- phase  output  2  envelope phase: 0=SILENT, 1=RISING, 2=STEADY, 3=FALLING.

Behaviour:
- Reset:
  - env_out=0, peak_out=0, env_valid=0, peak_valid=0, phase=SILENT.
  - Window count=0, running max=0, previous peak=0, pipeline registers cleared.
  - Asserting reset mid-window discards the partial window; counting restarts from sample 0 after release.
- Stage 1 (cycle after in_ready):
  - Register a = |sample_in|, saturated so -32768 gives 32767.
  - Register last = (count == WINDOW-1).
  - count wraps 0..WINDOW-1 and advances only on in_ready.
- Stage 2 (two cycles after in_ready):
  - If a > env: env += max(1, (a-env) >> ATTACK_SHIFT).
  - If a < env: env -= max(1, (env-a) >> RELEASE_SHIFT).
  - If a == env: env holds.
  - Compute in 17 bits; env never overshoots a and never leaves 0..32767.
  - env_valid pulses in the same cycle the new env_out appears. Latency from in_ready to env_valid is exactly 2 cycles.
- Window peak, in stage 2:
  - If last=0: running max <= max(running max, a).
  - If last=1: p = max(running max, a), so the boundary sample belongs to the closing window. Then peak_out <= p, peak_valid pulses, running max <= 0, phase updates, previous peak q <= p.
  - peak_valid therefore fires 2 cycles after the WINDOW-th strobe.
- Phase FSM, evaluated only when a window closes, in priority order (17-bit compares):
  - p < SILENCE -> SILENT.
  - p > q + HYST -> RISING.
  - p + HYST < q -> FALLING.
  - otherwise -> STEADY.
  - Any state may move to any state.
  - The first window after reset compares against q=0.
- Back-to-back in_ready on every cycle is fully pipelined with no lost samples.
- With in_ready low, all state holds and the valid pulses stay 0.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset check: assert reset asynchronously between clock edges -> all outputs 0 and phase=0 immediately, no clock edge needed.
- Attack step: default parameters, env=0, sample_in=+16384 on one strobe -> env_valid 2 cycles later with env_out=4096.
  - Continue strobing 16384 -> env_out=7168, then 9472, … converging to exactly 16384, never exceeding it.
- Saturation and first window: 480 strobes of -32768 -> env settles at 32767.
  - peak_valid pulses once, 2 cycles after the 480th strobe, with peak_out=32767 and phase=RISING.
  - A second identical window -> phase=STEADY.
- Release: env=32767, then samples of 0 -> first decrement is 511 (32767>>6), later steps shrink to 1, env reaches exactly 0.
  - Window of zeros -> peak_out=0, phase=SILENT.
- Hysteresis and boundary:
  - Window peaks 20000 then 10000 -> FALLING.
  - Window peaks 10000 then 10050 -> STEADY.
  - Window peaks 10000 then 10065 -> RISING.
  - A single 25000 sample placed exactly at strobe 480 is counted in the closing window's peak_out, not in the next window.
- Mid-window reset plus continuous strobes:
  - in_ready high every cycle for 300 samples, pulse reset, then 480 more samples -> exactly one peak_valid, 2 cycles after sample 480 post-reset.
  - No samples are dropped with continuous strobing.
